// File: rtl/ysyx_22040237_wb_pkg.sv
// Shared constants for the write-back controller and the register file.
package ysyx_22040237_wb_pkg;

   localparam int unsigned XLEN   = 64;
   localparam int unsigned REG_AW = 5;
   localparam int unsigned NREGS  = 32;

   localparam logic [REG_AW-1:0] REG_X0  = '0;
   localparam logic [XLEN-1:0]   RF_INIT = '0;

endpackage

// File: rtl/ysyx_22040237_wb_fifo.sv
// Synchronous FIFO holding load returns until the write port is free.
// Push and pop in the same cycle are both honoured, including when full.
module ysyx_22040237_wb_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 2,
   localparam int unsigned PW   = $clog2(DEPTH),
   localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PW-1:0]    rptr_q, rptr_d;
   logic [PW-1:0]    wptr_q, wptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      mem_d   = mem_q;
      rptr_d  = rptr_q;
      wptr_d  = wptr_q;
      do_pop  = pop && (count_q != '0);
      do_push = push && ((count_q != CW'(DEPTH)) || do_pop);
      if (do_push) begin
         mem_d[wptr_q] = din;
         wptr_d        = wptr_q + PW'(1);
      end
      if (do_pop) begin
         rptr_d = rptr_q + PW'(1);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rptr_q  <= '0;
         wptr_q  <= '0;
         count_q <= '0;
      end else begin
         rptr_q  <= rptr_d;
         wptr_q  <= wptr_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign dout  = mem_q[rptr_q];
   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;

endmodule

// File: rtl/ysyx_22040237_wb_ctrl.sv
// Write-back controller: arbitrates ALU results and queued load returns onto
// the register-file write port, and tracks in-flight load destinations.
module ysyx_22040237_wb_ctrl
   import ysyx_22040237_wb_pkg::*;
#(
   parameter int unsigned XLEN     = ysyx_22040237_wb_pkg::XLEN,
   parameter int unsigned LQ_DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              alu_valid,
   input  logic [REG_AW-1:0] alu_rd,
   input  logic [XLEN-1:0]   alu_data,
   input  logic              lsu_valid,
   output logic              lsu_ready,
   input  logic [REG_AW-1:0] lsu_rd,
   input  logic [XLEN-1:0]   lsu_data,
   input  logic              ld_issue,
   input  logic [REG_AW-1:0] ld_issue_rd,
   input  logic [REG_AW-1:0] chk_rs1,
   input  logic [REG_AW-1:0] chk_rs2,
   input  logic [REG_AW-1:0] chk_rd,
   output logic              hazard,
   output logic              reg_wr_en,
   output logic [REG_AW-1:0] wr_addr,
   output logic [XLEN-1:0]   wr_data,
   output logic              lq_empty
);

   localparam int unsigned CW = $clog2(LQ_DEPTH) + 1;
   localparam int unsigned EW = REG_AW + XLEN;

   logic [EW-1:0]     lq_head;
   logic [REG_AW-1:0] head_rd;
   logic [XLEN-1:0]   head_data;
   logic              lq_full, lq_nodata;
   logic [CW-1:0]     lq_count;
   logic              push, pop, alu_sel, set_busy, clr_busy;

   logic [NREGS-1:0]  busy_q, busy_d;
   logic              reg_wr_en_q, reg_wr_en_d;
   logic [REG_AW-1:0] wr_addr_q, wr_addr_d;
   logic [XLEN-1:0]   wr_data_q, wr_data_d;

   ysyx_22040237_wb_fifo #(
      .WIDTH (EW),
      .DEPTH (LQ_DEPTH)
   ) u_lq (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   ({lsu_rd, lsu_data}),
      .dout  (lq_head),
      .full  (lq_full),
      .empty (lq_nodata),
      .count (lq_count)
   );

   assign {head_rd, head_data} = lq_head;

   // Ready depends only on the registered count, never on this cycle's pop.
   assign lsu_ready = !rst && !lq_full;
   assign push      = lsu_valid && lsu_ready;
   assign alu_sel   = alu_valid && (alu_rd != REG_X0);
   assign pop       = !alu_sel && !lq_nodata;
   assign set_busy  = ld_issue && (ld_issue_rd != REG_X0);
   assign clr_busy  = pop && (head_rd != REG_X0);

   // Write selection and scoreboard update; a coincident set wins over clear.
   always_comb begin
      reg_wr_en_d = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      busy_d      = busy_q;
      if (alu_sel) begin
         reg_wr_en_d = 1'b1;
         wr_addr_d   = alu_rd;
         wr_data_d   = alu_data;
      end else if (clr_busy) begin
         reg_wr_en_d = 1'b1;
         wr_addr_d   = head_rd;
         wr_data_d   = head_data;
      end
      if (clr_busy) begin
         busy_d[head_rd] = 1'b0;
      end
      if (set_busy) begin
         busy_d[ld_issue_rd] = 1'b1;
      end
      busy_d[REG_X0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         reg_wr_en_q <= 1'b0;
         wr_addr_q   <= REG_X0;
         wr_data_q   <= RF_INIT;
         busy_q      <= '0;
      end else begin
         reg_wr_en_q <= reg_wr_en_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         busy_q      <= busy_d;
      end
   end

   assign reg_wr_en = reg_wr_en_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;
   assign hazard    = busy_q[chk_rs1] | busy_q[chk_rs2] | busy_q[chk_rd];
   assign lq_empty  = rst || ((lq_count == '0) && (busy_q == '0));

   // Issue logic must never set and clear the same register in one cycle.
   a_no_set_clr: assert property (@(posedge clk) disable iff (rst)
      !(set_busy && clr_busy && (ld_issue_rd == head_rd)));

   // Every nonzero load return must target a register with a load in flight.
   a_ret_busy: assert property (@(posedge clk) disable iff (rst)
      !(push && (lsu_rd != REG_X0) && !busy_q[lsu_rd]));

endmodule

// File: tb/tb_ysyx_22040237_wb_ctrl.sv
// Self-checking bench: queue/array model of the write-back rules plus directed scenarios.
module tb_ysyx_22040237_wb_ctrl;

   localparam int unsigned XLEN  = 64;
   localparam int unsigned DEPTH = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic            alu_valid;
   logic [4:0]      alu_rd;
   logic [XLEN-1:0] alu_data;
   logic            lsu_valid;
   logic            lsu_ready;
   logic [4:0]      lsu_rd;
   logic [XLEN-1:0] lsu_data;
   logic            ld_issue;
   logic [4:0]      ld_issue_rd;
   logic [4:0]      chk_rs1, chk_rs2, chk_rd;
   logic            hazard;
   logic            reg_wr_en;
   logic [4:0]      wr_addr;
   logic [XLEN-1:0] wr_data;
   logic            lq_empty;

   always #5 clk = ~clk;

   ysyx_22040237_wb_ctrl #(.XLEN(XLEN), .LQ_DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .alu_valid   (alu_valid),
      .alu_rd      (alu_rd),
      .alu_data    (alu_data),
      .lsu_valid   (lsu_valid),
      .lsu_ready   (lsu_ready),
      .lsu_rd      (lsu_rd),
      .lsu_data    (lsu_data),
      .ld_issue    (ld_issue),
      .ld_issue_rd (ld_issue_rd),
      .chk_rs1     (chk_rs1),
      .chk_rs2     (chk_rs2),
      .chk_rd      (chk_rd),
      .hazard      (hazard),
      .reg_wr_en   (reg_wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .lq_empty    (lq_empty)
   );

   typedef struct {
      logic [4:0]      rd;
      logic [XLEN-1:0] data;
   } ent_t;

   ent_t            lq[$];
   bit              busy_m [32];
   logic            m_en;
   logic [4:0]      m_addr;
   logic [XLEN-1:0] m_data;
   logic [4:0]      pend[$];
   bit              last_acc;
   int              checks = 0;
   int              errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit any_busy();
      bit b = 1'b0;
      for (int i = 0; i < 32; i++) b |= busy_m[i];
      return b;
   endfunction

   task automatic idle();
      alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
      lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
      ld_issue = 1'b0; ld_issue_rd = '0;
      chk_rs1 = '0; chk_rs2 = '0; chk_rd = '0;
   endtask

   // One clock: check combinational outputs, advance the model, check the write port.
   task automatic tick();
      bit   rdy, in_rst;
      ent_t h, e;
      #1;
      in_rst = rst;
      rdy = !rst && (lq.size() < DEPTH);
      check("lsu_ready", 64'(lsu_ready), 64'(rdy));
      check("hazard", 64'(hazard), 64'(busy_m[chk_rs1] | busy_m[chk_rs2] | busy_m[chk_rd]));
      check("lq_empty", 64'(lq_empty), 64'(rst || (lq.size() == 0 && !any_busy())));
      last_acc = 1'b0;
      if (rst) begin
         lq.delete();
         for (int i = 0; i < 32; i++) busy_m[i] = 1'b0;
         m_en = 1'b0; m_addr = '0; m_data = '0;
      end else begin
         m_en = 1'b0;
         if (alu_valid && alu_rd != 0) begin
            m_en = 1'b1; m_addr = alu_rd; m_data = alu_data;
         end else if (lq.size() > 0) begin
            h = lq.pop_front();
            if (h.rd != 0) begin
               m_en = 1'b1; m_addr = h.rd; m_data = h.data;
               busy_m[h.rd] = 1'b0;
            end
         end
         if (lsu_valid && rdy) begin
            e.rd = lsu_rd; e.data = lsu_data;
            lq.push_back(e);
            last_acc = 1'b1;
         end
         if (ld_issue && ld_issue_rd != 0) busy_m[ld_issue_rd] = 1'b1;
      end
      @(posedge clk);
      #1;
      check("reg_wr_en", 64'(reg_wr_en), 64'(m_en));
      if (m_en || in_rst) begin
         check("wr_addr", 64'(wr_addr), 64'(m_addr));
         check("wr_data", wr_data, m_data);
      end
      @(negedge clk);
   endtask

   initial begin
      int k, w, idx;
      logic [4:0] r;
      idle();
      rst = 1'b1;
      m_en = 1'b0; m_addr = '0; m_data = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      tick();
      check("rst_wr_en", 64'(reg_wr_en), 64'd0);
      check("rst_wr_addr", 64'(wr_addr), 64'd0);
      check("rst_wr_data", wr_data, 64'd0);
      check("rst_ready", 64'(lsu_ready), 64'd0);
      check("rst_lq_empty", 64'(lq_empty), 64'd1);
      rst = 1'b0;

      // ALU write appears one cycle later for exactly one cycle
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'h1234;
      tick();
      check("t1_en", 64'(reg_wr_en), 64'd1);
      check("t1_addr", 64'(wr_addr), 64'd5);
      check("t1_data", wr_data, 64'h1234);
      idle();
      tick();
      check("t1_en_low", 64'(reg_wr_en), 64'd0);

      // Load hazard and return latency
      ld_issue = 1'b1; ld_issue_rd = 5'd7;
      tick();
      idle(); chk_rs1 = 5'd7;
      #1 check("t2_hazard_set", 64'(hazard), 64'd1);
      lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 64'hDEAD;
      tick();
      lsu_valid = 1'b0;
      tick();
      check("t2_en", 64'(reg_wr_en), 64'd1);
      check("t2_addr", 64'(wr_addr), 64'd7);
      check("t2_data", wr_data, 64'hDEAD);
      #1 check("t2_hazard_clr", 64'(hazard), 64'd0);

      // Loads back up behind a held ALU stream
      idle();
      alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 64'h33;
      ld_issue = 1'b1; ld_issue_rd = 5'd10;
      tick();
      ld_issue_rd = 5'd11;
      tick();
      ld_issue = 1'b0;
      lsu_valid = 1'b1; lsu_rd = 5'd10; lsu_data = 64'hA0;
      tick();
      lsu_rd = 5'd11; lsu_data = 64'hB0;
      tick();
      lsu_valid = 1'b0;
      #1 check("t3_ready_full", 64'(lsu_ready), 64'd0);
      check("t3_alu_addr", 64'(wr_addr), 64'd3);
      alu_valid = 1'b0;
      tick();
      check("t3_first_load", 64'(wr_addr), 64'd10);
      check("t3_first_data", wr_data, 64'hA0);
      #1 check("t3_ready_back", 64'(lsu_ready), 64'd1);
      tick();
      check("t3_second_load", 64'(wr_addr), 64'd11);

      // ALU to x0 does not block a FIFO pop
      idle();
      ld_issue = 1'b1; ld_issue_rd = 5'd9;
      tick();
      idle();
      lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 64'h99;
      tick();
      lsu_valid = 1'b0;
      alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 64'hBAD;
      tick();
      check("t4_en", 64'(reg_wr_en), 64'd1);
      check("t4_addr", 64'(wr_addr), 64'd9);
      check("t4_data", wr_data, 64'h99);
      idle();
      tick();
      check("t4_no_x0", 64'(reg_wr_en), 64'd0);

      // Reset with a full queue and busy registers
      alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 64'h1;
      ld_issue = 1'b1; ld_issue_rd = 5'd12;
      tick();
      ld_issue_rd = 5'd13;
      lsu_valid = 1'b1; lsu_rd = 5'd12; lsu_data = 64'h12;
      tick();
      ld_issue = 1'b0;
      lsu_rd = 5'd13; lsu_data = 64'h13;
      tick();
      idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_rs1 = 5'd12; chk_rs2 = 5'd13;
      #1 check("t5_lq_empty", 64'(lq_empty), 64'd1);
      check("t5_hazard", 64'(hazard), 64'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("t5_no_write", 64'(reg_wr_en), 64'd0);
      end

      // Streaming push and pop starting from a full queue
      idle();
      for (int i = 0; i < 10; i++) begin
         ld_issue = 1'b1; ld_issue_rd = 5'(14 + i);
         tick();
      end
      ld_issue = 1'b0;
      k = 0; w = 0;
      alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 64'h2;
      for (int c = 0; c < 40 && w < 10; c++) begin
         lsu_valid = (k < 10);
         lsu_rd    = 5'(14 + k);
         lsu_data  = 64'hC000 + 64'(k);
         if (k >= 2) alu_valid = 1'b0;
         tick();
         if (last_acc) k++;
         if (reg_wr_en && wr_addr >= 5'd14 && wr_addr <= 5'd23) begin
            check("t6_order", 64'(wr_addr), 64'(14 + w));
            check("t6_data", wr_data, 64'hC000 + 64'(w));
            w++;
         end
      end
      check("t6_count", 64'(w), 64'd10);

      // Randomised traffic against the model
      idle();
      for (int c = 0; c < 3000; c++) begin
         rst       = ($urandom_range(0, 299) == 0);
         alu_valid = $urandom_range(0, 1) == 1;
         alu_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         alu_data  = {$urandom, $urandom};
         chk_rs1   = 5'($urandom_range(0, 31));
         chk_rs2   = 5'($urandom_range(0, 31));
         chk_rd    = 5'($urandom_range(0, 31));
         ld_issue  = 1'b0;
         if ($urandom_range(0, 2) == 0) begin
            r = 5'($urandom_range(1, 31));
            if (!busy_m[r]) begin
               ld_issue = 1'b1; ld_issue_rd = r;
            end
         end
         if (!lsu_valid) begin
            if (pend.size() > 0 && $urandom_range(0, 1) == 1) begin
               idx = $urandom_range(0, pend.size() - 1);
               lsu_valid = 1'b1; lsu_rd = pend[idx]; lsu_data = {$urandom, $urandom};
            end else if ($urandom_range(0, 15) == 0) begin
               lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = {$urandom, $urandom};
            end
         end
         tick();
         if (ld_issue && !rst) pend.push_back(ld_issue_rd);
         if (last_acc) begin
            for (int i = 0; i < pend.size(); i++) begin
               if (pend[i] == lsu_rd && lsu_rd != 0) begin
                  pend.delete(i);
                  break;
               end
            end
            lsu_valid = 1'b0;
         end
         if (rst) begin
            pend.delete();
            lsu_valid = 1'b0;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
